// File: rtl/uart_cfg_pkg.sv
// Shared encodings, FSM states and limits for the runtime-configurable UART.
package uart_cfg_pkg;

  localparam logic [1:0] PAR_NONE     = 2'b00;
  localparam logic [1:0] PAR_EVEN     = 2'b01;
  localparam logic [1:0] PAR_ODD      = 2'b10;
  localparam logic [1:0] PAR_NONE_ALT = 2'b11;

  localparam int MIN_CPB       = 4;
  localparam int MIN_DATA_BITS = 5;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START_CHK,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK_WAIT
  } rx_state_e;

endpackage

// File: rtl/uart_cfg_rx.sv
// UART receiver on the synchronised line: start validation, mid-bit sampling, error and break reporting.
module uart_cfg_rx
  import uart_cfg_pkg::*;
#(
  parameter int DIV_W      = 16,
  parameter int MAX_DATA_W = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  rx_s,
  input  logic [DIV_W-1:0]      cpb,
  input  logic [3:0]            nbits,
  input  logic                  par_en,
  input  logic                  par_odd,
  output logic [MAX_DATA_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_parity_err,
  output logic                  rx_frame_err,
  output logic                  rx_break
);

  rx_state_e             state_q, state_d;
  logic [DIV_W-1:0]      cnt_q, cnt_d;
  logic [DIV_W-1:0]      cpb_q, cpb_d;
  logic [3:0]            bit_q, bit_d;
  logic [3:0]            nbits_q, nbits_d;
  logic                  par_en_q, par_en_d;
  logic                  par_odd_q, par_odd_d;
  logic [MAX_DATA_W-1:0] shift_q, shift_d;
  logic                  zero_q, zero_d;
  logic                  par_acc_q, par_acc_d;
  logic                  prev_q, prev_d;
  logic [MAX_DATA_W-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic                  brk_q, brk_d;

  logic sample_half;
  logic sample_full;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cpb_d     = cpb_q;
    bit_d     = bit_q;
    nbits_d   = nbits_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    shift_d   = shift_q;
    zero_d    = zero_q;
    par_acc_d = par_acc_q;
    prev_d    = rx_s;
    data_d    = data_q;
    valid_d   = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    brk_d     = 1'b0;

    sample_half = (cnt_q == (cpb_q >> 1) - 1'b1);
    sample_full = (cnt_q == cpb_q - 1'b1);

    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (en && prev_q && !rx_s) begin
          state_d   = RX_START_CHK;
          cpb_d     = cpb;
          nbits_d   = nbits;
          par_en_d  = par_en;
          par_odd_d = par_odd;
        end
      end
      RX_START_CHK: begin
        cnt_d = cnt_q + 1'b1;
        if (sample_half) begin
          cnt_d     = '0;
          bit_d     = '0;
          shift_d   = '0;
          zero_d    = 1'b1;
          par_acc_d = 1'b0;
          state_d   = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (sample_full) begin
          cnt_d          = '0;
          shift_d[bit_q] = rx_s;
          zero_d         = zero_q & ~rx_s;
          par_acc_d      = par_acc_q ^ rx_s;
          if (bit_q == nbits_q - 1'b1) state_d = par_en_q ? RX_PARITY : RX_STOP;
          else                         bit_d   = bit_q + 1'b1;
        end
      end
      RX_PARITY: begin
        cnt_d = cnt_q + 1'b1;
        if (sample_full) begin
          cnt_d     = '0;
          zero_d    = zero_q & ~rx_s;
          par_acc_d = par_acc_q ^ rx_s;
          state_d   = RX_STOP;
        end
      end
      RX_STOP: begin
        cnt_d = cnt_q + 1'b1;
        if (sample_full) begin
          cnt_d   = '0;
          valid_d = 1'b1;
          data_d  = shift_q;
          ferr_d  = !rx_s;
          brk_d   = zero_q && !rx_s;
          // Accumulated XOR over data and parity must equal 1 for odd, 0 for even.
          perr_d  = par_en_q && (par_acc_q != par_odd_q);
          state_d = (zero_q && !rx_s) ? RX_BREAK_WAIT : RX_IDLE;
        end
      end
      RX_BREAK_WAIT: begin
        if (!rx_s) begin
          cnt_d = '0;
        end else if (sample_full) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      cpb_q     <= '0;
      bit_q     <= '0;
      nbits_q   <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      shift_q   <= '0;
      zero_q    <= 1'b0;
      par_acc_q <= 1'b0;
      prev_q    <= 1'b1;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cpb_q     <= cpb_d;
      bit_q     <= bit_d;
      nbits_q   <= nbits_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
      shift_q   <= shift_d;
      zero_q    <= zero_d;
      par_acc_q <= par_acc_d;
      prev_q    <= prev_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      brk_q     <= brk_d;
    end
  end

  assign rx_data       = data_q;
  assign rx_valid      = valid_q;
  assign rx_parity_err = perr_q;
  assign rx_frame_err  = ferr_q;
  assign rx_break      = brk_q;

endmodule

// File: rtl/uart_cfg_sync.sv
// Multi-flop synchroniser for the asynchronous RX pin; resets to the idle-high level.
module uart_cfg_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign sync_d[gi] = async_in;
      end else begin : g_next
        assign sync_d[gi] = sync_q[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= sync_d;
  end

  assign sync_out = sync_q[STAGES-1];

endmodule

// File: rtl/uart_cfg_tx.sv
// UART transmitter: frame configuration is latched on acceptance, each bit lasts cpb cycles.
module uart_cfg_tx
  import uart_cfg_pkg::*;
#(
  parameter int DIV_W      = 16,
  parameter int MAX_DATA_W = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DIV_W-1:0]      cpb,
  input  logic [3:0]            nbits,
  input  logic                  par_en,
  input  logic                  par_odd,
  input  logic                  two_stop,
  input  logic [MAX_DATA_W-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_line
);

  tx_state_e             state_q, state_d;
  logic [DIV_W-1:0]      cnt_q, cnt_d;
  logic [DIV_W-1:0]      cpb_q, cpb_d;
  logic [3:0]            bit_q, bit_d;
  logic [3:0]            nbits_q, nbits_d;
  logic [MAX_DATA_W-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  two_stop_q, two_stop_d;
  logic                  line_q, line_d;
  logic                  ready_q, ready_d;

  logic wrap;
  logic last_stop;
  logic accept;
  logic par_calc;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cpb_d      = cpb_q;
    bit_d      = bit_q;
    nbits_d    = nbits_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    two_stop_d = two_stop_q;
    line_d     = line_q;
    ready_d    = ready_q;

    par_calc = 1'b0;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      if (4'(i) < nbits) par_calc = par_calc ^ tx_data[i];
    end

    wrap      = (cnt_q == cpb_q - 1'b1);
    last_stop = !two_stop_q || (bit_q == 4'd1);
    accept    = tx_valid && ready_q && en;

    if (state_q != TX_IDLE) cnt_d = wrap ? '0 : cnt_q + 1'b1;

    case (state_q)
      TX_IDLE: begin
        cnt_d   = '0;
        line_d  = 1'b1;
        ready_d = en;
      end
      TX_START: begin
        if (wrap) begin
          state_d = TX_DATA;
          bit_d   = '0;
          line_d  = shift_q[0];
        end
      end
      TX_DATA: begin
        if (wrap) begin
          if (bit_q == nbits_q - 1'b1) begin
            bit_d = '0;
            if (par_en_q) begin
              state_d = TX_PARITY;
              line_d  = par_bit_q;
            end else begin
              state_d = TX_STOP;
              line_d  = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            line_d  = shift_q[1];
          end
        end
      end
      TX_PARITY: begin
        if (wrap) begin
          state_d = TX_STOP;
          bit_d   = '0;
          line_d  = 1'b1;
        end
      end
      TX_STOP: begin
        // Ready is raised one cycle early so a waiting word starts with no idle gap.
        if (last_stop && (cnt_q == cpb_q - 2'd2) && en) ready_d = 1'b1;
        if (wrap) begin
          if (!last_stop) bit_d = 4'd1;
          else            state_d = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase

    if (accept) begin
      state_d    = TX_START;
      cnt_d      = '0;
      bit_d      = '0;
      line_d     = 1'b0;
      ready_d    = 1'b0;
      shift_d    = tx_data;
      cpb_d      = cpb;
      nbits_d    = nbits;
      par_en_d   = par_en;
      par_bit_d  = par_calc ^ par_odd;
      two_stop_d = two_stop;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= TX_IDLE;
      cnt_q      <= '0;
      cpb_q      <= '0;
      bit_q      <= '0;
      nbits_q    <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      line_q     <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cpb_q      <= cpb_d;
      bit_q      <= bit_d;
      nbits_q    <= nbits_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop_d;
      line_q     <= line_d;
      ready_q    <= ready_d;
    end
  end

  assign tx_ready = ready_q;
  assign tx_line  = line_q;

endmodule

// File: rtl/uart_cfg_controller.sv
// Full-duplex configurable UART port: input synchroniser, config clamping, overrun tracking.
module uart_cfg_controller
  import uart_cfg_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int MAX_DATA_W  = 9,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DIV_W-1:0]      clks_per_bit,
  input  logic [3:0]            data_bits,
  input  logic [1:0]            parity_mode,
  input  logic                  two_stop,
  input  logic [MAX_DATA_W-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_line,
  input  logic                  rx_line,
  output logic [MAX_DATA_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_parity_err,
  output logic                  rx_frame_err,
  output logic                  rx_break,
  output logic                  rx_overrun,
  input  logic                  rx_ack
);

  logic [DIV_W-1:0] cpb_eff;
  logic [3:0]       nbits_eff;
  logic             par_en;
  logic             par_odd;
  logic             rx_s;
  logic             pending_q, pending_d;
  logic             overrun_q, overrun_d;

  always_comb begin
    cpb_eff = (clks_per_bit < DIV_W'(MIN_CPB)) ? DIV_W'(MIN_CPB) : clks_per_bit;
    if (data_bits < 4'(MIN_DATA_BITS))   nbits_eff = 4'(MIN_DATA_BITS);
    else if (data_bits > 4'(MAX_DATA_W)) nbits_eff = 4'(MAX_DATA_W);
    else                                 nbits_eff = data_bits;
    par_en  = (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
    par_odd = (parity_mode == PAR_ODD);
  end

  uart_cfg_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk      (sys_clk),
    .rst_n    (rst_n),
    .async_in (rx_line),
    .sync_out (rx_s)
  );

  uart_cfg_tx #(.DIV_W(DIV_W), .MAX_DATA_W(MAX_DATA_W)) u_tx (
    .clk      (sys_clk),
    .rst_n    (rst_n),
    .en       (en),
    .cpb      (cpb_eff),
    .nbits    (nbits_eff),
    .par_en   (par_en),
    .par_odd  (par_odd),
    .two_stop (two_stop),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_line  (tx_line)
  );

  uart_cfg_rx #(.DIV_W(DIV_W), .MAX_DATA_W(MAX_DATA_W)) u_rx (
    .clk           (sys_clk),
    .rst_n         (rst_n),
    .en            (en),
    .rx_s          (rx_s),
    .cpb           (cpb_eff),
    .nbits         (nbits_eff),
    .par_en        (par_en),
    .par_odd       (par_odd),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_parity_err (rx_parity_err),
    .rx_frame_err  (rx_frame_err),
    .rx_break      (rx_break)
  );

  // An ack in the same cycle as a new strobe retires the old word, so no overrun.
  always_comb begin
    pending_d = rx_valid ? 1'b1 : (rx_ack ? 1'b0 : pending_q);
    overrun_d = rx_ack ? 1'b0 : ((rx_valid && pending_q) ? 1'b1 : overrun_q);
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign rx_overrun = overrun_q;

endmodule

// File: tb/tb_uart_cfg_controller.sv
// Scoreboard bench for uart_cfg_controller: TX pattern, loopback, false start, errors, overrun, reset.
module tb_uart_cfg_controller;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] clks_per_bit;
  logic [3:0]  data_bits;
  logic [1:0]  parity_mode;
  logic        two_stop;
  logic [8:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_line;
  logic        rx_line;
  logic [8:0]  rx_data;
  logic        rx_valid;
  logic        rx_parity_err;
  logic        rx_frame_err;
  logic        rx_break;
  logic        rx_overrun;
  logic        rx_ack;

  logic loop_en, rx_drive, auto_ack, ack_auto, ack_dly, ack_man;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_valid_cyc = 0;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } rx_exp_t;
  rx_exp_t sb_q[$];

  localparam int SYNC = 2;

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  assign rx_line = loop_en ? tx_line : rx_drive;
  assign rx_ack  = ack_auto | ack_man;

  uart_cfg_controller dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .en(en), .clks_per_bit(clks_per_bit),
    .data_bits(data_bits), .parity_mode(parity_mode), .two_stop(two_stop),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_line(tx_line),
    .rx_line(rx_line), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err), .rx_break(rx_break),
    .rx_overrun(rx_overrun), .rx_ack(rx_ack)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end else begin
      $display("ok   %s: 0x%0h (cycle %0d)", tag, got, cyc);
    end
  endtask

  // RX scoreboard: every strobe must match the oldest expected word; ack one cycle later.
  always @(negedge sys_clk) begin
    rx_exp_t e;
    ack_auto = ack_dly;
    ack_dly  = auto_ack && rx_valid;
    if (rx_valid) begin
      last_valid_cyc = cyc;
      check_eq("rx_strobe_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check_eq("rx_data", 32'(rx_data), 32'(e.data));
        check_eq("rx_parity_err", 32'(rx_parity_err), 32'(e.perr));
        check_eq("rx_frame_err", 32'(rx_frame_err), 32'(e.ferr));
        check_eq("rx_break", 32'(rx_break), 32'(e.brk));
      end
    end
  end

  function automatic int clamp_nb(input int nb);
    return (nb < 5) ? 5 : ((nb > 9) ? 9 : nb);
  endfunction

  task automatic push_exp(input logic [8:0] d, input logic pe, input logic fe, input logic bk);
    rx_exp_t e;
    e.data = d; e.perr = pe; e.ferr = fe; e.brk = bk;
    sb_q.push_back(e);
  endtask

  task automatic set_cfg(input int cpbv, input int nb, input logic [1:0] pm, input logic ts);
    clks_per_bit = 16'(cpbv);
    data_bits    = 4'(nb);
    parity_mode  = pm;
    two_stop     = ts;
  endtask

  task automatic send_tx(input logic [8:0] d);
    int n = 0;
    while (!tx_ready && n < 1000) begin
      @(negedge sys_clk);
      n++;
    end
    check_eq("tx_ready_wait", 32'(tx_ready), 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge sys_clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_rx_done(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    check_eq("rx_drain", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic drive_frame(input logic [8:0] d, input int nb, input logic [1:0] pm,
                             input bit stop_low, input int cpbv, output int t0);
    logic p;
    p  = 1'b0;
    t0 = cyc;
    rx_drive = 1'b0;
    repeat (cpbv) @(negedge sys_clk);
    for (int i = 0; i < nb; i++) begin
      rx_drive = d[i];
      p = p ^ d[i];
      repeat (cpbv) @(negedge sys_clk);
    end
    if (pm == 2'b01 || pm == 2'b10) begin
      rx_drive = p ^ (pm == 2'b10);
      repeat (cpbv) @(negedge sys_clk);
    end
    rx_drive = !stop_low;
    repeat (cpbv) @(negedge sys_clk);
    rx_drive = 1'b1;
    repeat (cpbv) @(negedge sys_clk);
  endtask

  task automatic loopback(input logic [8:0] d, input int nb, input logic [1:0] pm,
                          input logic ts, input int cpbv);
    int          enb;
    logic [8:0]  mask;
    enb  = clamp_nb(nb);
    mask = 9'((1 << enb) - 1);
    set_cfg(cpbv, nb, pm, ts);
    push_exp(d & mask, 1'b0, 1'b0, 1'b0);
    send_tx(d);
    wait_rx_done(20 * ((cpbv < 4) ? 4 : cpbv) + 100);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] fb;
    int         t0;
    rst_n = 1'b0; en = 1'b1; tx_data = '0; tx_valid = 1'b0;
    loop_en = 1'b0; rx_drive = 1'b1; auto_ack = 1'b1; ack_auto = 1'b0; ack_dly = 1'b0; ack_man = 1'b0;
    set_cfg(8, 8, 2'b00, 1'b0);

    // Reset state
    repeat (3) @(negedge sys_clk);
    check_eq("rst_tx_line", 32'(tx_line), 32'd1);
    check_eq("rst_tx_ready", 32'(tx_ready), 32'd0);
    check_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
    check_eq("rst_rx_data", 32'(rx_data), 32'd0);
    check_eq("rst_flags", 32'({rx_parity_err, rx_frame_err, rx_break, rx_overrun}), 32'd0);
    rst_n = 1'b1;
    @(negedge sys_clk);
    check_eq("tx_ready_after_rst", 32'(tx_ready), 32'd1);

    // 8N1 0xA5 at 8 clocks/bit: check every cycle of the frame
    fb = {1'b1, 8'hA5, 1'b0};
    send_tx(9'h0A5);
    for (int k = 1; k <= 80; k++) begin
      check_eq($sformatf("tx_a5_line_c%0d", k), 32'(tx_line), 32'(fb[(k-1)/8]));
      check_eq($sformatf("tx_a5_ready_c%0d", k), 32'(tx_ready), 32'(k == 80));
      @(negedge sys_clk);
    end
    check_eq("tx_a5_idle_line", 32'(tx_line), 32'd1);
    check_eq("tx_a5_idle_ready", 32'(tx_ready), 32'd1);

    // Loopback 7 bits, odd parity, 2 stop: parity bit of 0x55 is 1
    loop_en = 1'b1;
    set_cfg(8, 7, 2'b10, 1'b1);
    push_exp(9'h055, 1'b0, 1'b0, 1'b0);
    send_tx(9'h055);
    repeat (67) @(negedge sys_clk);
    check_eq("tx_odd_parity_bit", 32'(tx_line), 32'd1);
    wait_rx_done(300);

    // Clamped configurations and back-to-back traffic
    loopback(9'h03F, 4, 2'b00, 1'b0, 2);
    loopback(9'h1A5, 12, 2'b01, 1'b0, 6);
    loopback(9'h0C3, 8, 2'b11, 1'b1, 5);
    loop_en = 1'b0;

    // False start: 3-cycle low pulse, then a valid frame with exact latency
    set_cfg(16, 8, 2'b00, 1'b0);
    repeat (20) @(negedge sys_clk);
    rx_drive = 1'b0;
    repeat (3) @(negedge sys_clk);
    rx_drive = 1'b1;
    repeat (16) @(negedge sys_clk);
    push_exp(9'h096, 1'b0, 1'b0, 1'b0);
    drive_frame(9'h096, 8, 2'b00, 1'b0, 16, t0);
    wait_rx_done(50);
    check_eq("rx_latency", 32'(last_valid_cyc - t0), 32'(SYNC + 16 / 2 + 9 * 16 + 1));

    // Even parity frame with a corrupted parity bit (drive as odd)
    set_cfg(16, 8, 2'b01, 1'b0);
    push_exp(9'h0F1, 1'b1, 1'b0, 1'b0);
    drive_frame(9'h0F1, 8, 2'b10, 1'b0, 16, t0);
    wait_rx_done(50);

    // Framing error, then break, then guard period before the next frame
    set_cfg(16, 8, 2'b00, 1'b0);
    push_exp(9'h03C, 1'b0, 1'b1, 1'b0);
    drive_frame(9'h03C, 8, 2'b00, 1'b1, 16, t0);
    wait_rx_done(50);
    push_exp(9'h000, 1'b0, 1'b1, 1'b1);
    rx_drive = 1'b0;
    repeat (12 * 16) @(negedge sys_clk);
    rx_drive = 1'b1;
    repeat (8) @(negedge sys_clk);
    rx_drive = 1'b0;
    repeat (48) @(negedge sys_clk);
    rx_drive = 1'b1;
    repeat (40) @(negedge sys_clk);
    wait_rx_done(10);
    push_exp(9'h081, 1'b0, 1'b0, 1'b0);
    drive_frame(9'h081, 8, 2'b00, 1'b0, 16, t0);
    wait_rx_done(50);

    // Overrun: two words without ack, then a single ack clears it
    repeat (4) @(negedge sys_clk);
    auto_ack = 1'b0;
    push_exp(9'h011, 1'b0, 1'b0, 1'b0);
    drive_frame(9'h011, 8, 2'b00, 1'b0, 16, t0);
    check_eq("overrun_after_first", 32'(rx_overrun), 32'd0);
    push_exp(9'h022, 1'b0, 1'b0, 1'b0);
    drive_frame(9'h022, 8, 2'b00, 1'b0, 16, t0);
    check_eq("overrun_after_second", 32'(rx_overrun), 32'd1);
    ack_man = 1'b1;
    @(negedge sys_clk);
    ack_man = 1'b0;
    @(negedge sys_clk);
    check_eq("overrun_cleared", 32'(rx_overrun), 32'd0);
    auto_ack = 1'b1;
    wait_rx_done(10);

    // Reset mid-TX at line bit 4 with loopback: frame aborted, nothing received
    loop_en = 1'b1;
    set_cfg(8, 8, 2'b00, 1'b0);
    send_tx(9'h000);
    repeat (35) @(negedge sys_clk);
    check_eq("tx_line_before_rst", 32'(tx_line), 32'd0);
    rst_n = 1'b0;
    @(negedge sys_clk);
    check_eq("tx_line_after_rst", 32'(tx_line), 32'd1);
    check_eq("tx_ready_in_rst", 32'(tx_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge sys_clk);
    check_eq("tx_ready_after_release", 32'(tx_ready), 32'd1);
    repeat (200) @(negedge sys_clk);

    check_eq("sb_final_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
